// File: rtl/left_shift_seq.sv
// Iterative left shifter/rotator: moves the operand one bit position per clock
// until the captured count is exhausted, then presents the result with a done pulse.
module left_shift_seq #(
    parameter int N = 16,
    parameter int C = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] In,
    input  logic [C-1:0] Cnt,
    input  logic         Op,
    output logic [N-1:0] Out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [N-1:0] r_work;
    logic [N-1:0] r_out;
    logic [C-1:0] r_remaining;
    logic         r_op;

    logic [N-1:0] w_shifted;
    logic         w_accept;
    logic         w_last;

    // Rotate feeds the outgoing MSB back into bit 0; logical shift fills with zero.
    assign w_shifted = {r_work[N-2:0], (r_op ? r_work[N-1] : 1'b0)};
    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last    = (r_state == S_SHIFT) && (r_remaining == C'(1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (Cnt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_next = (Cnt == '0) ? S_DONE : S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_out       <= '0;
            r_remaining <= '0;
            r_op        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_work      <= In;
                r_remaining <= Cnt;
                r_op        <= Op;
                // A zero count bypasses the shift phase entirely.
                if (Cnt == '0) begin
                    r_out <= In;
                end
            end else if (r_state == S_SHIFT) begin
                r_work      <= w_shifted;
                r_remaining <= r_remaining - C'(1);
                if (w_last) begin
                    r_out <= w_shifted;
                end
            end
        end
    end

    assign Out  = r_out;
    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_left_shift_seq.sv
// Directed and swept checks of left_shift_seq: results, busy/done timing,
// ignored starts, back-to-back jobs and mid-job reset.
module tb_left_shift_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic        Op;
    logic [15:0] Out;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_fail;
    logic [15:0] last_out;

    left_shift_seq #(.N(16), .C(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (In),
        .Cnt   (Cnt),
        .Op    (Op),
        .Out   (Out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] in_v;
        logic [3:0]  cnt_v;
        logic        op_v;
        logic [15:0] exp_v;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered just after a negedge; accepts on the next posedge and checks
    // every cycle through done plus one idle cycle afterwards.
    task automatic run_job(input logic [15:0] in_v, input logic [3:0] cnt_v,
                           input logic op_v, input logic [15:0] exp_v);
        int n;
        n = int'(cnt_v);
        start = 1'b1; In = in_v; Cnt = cnt_v; Op = op_v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; In = ~in_v; Cnt = ~cnt_v; Op = ~op_v;
        for (int c = 1; c <= n + 1; c++) begin
            if (c > 1) @(negedge clk);
            chk("busy", {31'd0, busy}, {31'd0, (c <= n)});
            chk("done", {31'd0, done}, {31'd0, (c == n + 1)});
            if (c <= n) chk("out_hold", {16'd0, Out}, {16'd0, last_out});
        end
        chk("out", {16'd0, Out}, {16'd0, exp_v});
        $display("job In=%h Cnt=%0d Op=%0d -> Out=%h (exp %h)", in_v, cnt_v, op_v, Out, exp_v);
        last_out = exp_v;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_out", {16'd0, Out}, {16'd0, exp_v});
    endtask

    initial begin
        vec_t vecs[10];
        logic [15:0] rin;
        logic [31:0] dbl;
        logic [15:0] exp_r;

        n_cmp = 0; n_fail = 0; last_out = 16'h0000;
        rst = 1'b1; start = 1'b0; In = 16'h0; Cnt = 4'h0; Op = 1'b0;

        vecs[0] = '{16'h8001, 4'd1,  1'b0, 16'h0002};
        vecs[1] = '{16'h8001, 4'd1,  1'b1, 16'h0003};
        vecs[2] = '{16'hFFFF, 4'd15, 1'b0, 16'h8000};
        vecs[3] = '{16'hFFFF, 4'd15, 1'b1, 16'hFFFF};
        vecs[4] = '{16'h1234, 4'd15, 1'b1, 16'h091A};
        vecs[5] = '{16'hA5A5, 4'd0,  1'b0, 16'hA5A5};
        vecs[6] = '{16'h00F0, 4'd4,  1'b0, 16'h0F00};
        vecs[7] = '{16'hF00F, 4'd4,  1'b1, 16'h00FF};
        vecs[8] = '{16'h8421, 4'd3,  1'b0, 16'h2108};
        vecs[9] = '{16'hC003, 4'd2,  1'b1, 16'h000F};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out",  {16'd0, Out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_job(vecs[i].in_v, vecs[i].cnt_v, vecs[i].op_v, vecs[i].exp_v);
        end

        // Job A with a start pulse during SHIFT, then job B accepted in A's done cycle.
        start = 1'b1; In = 16'h0001; Cnt = 4'd4; Op = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; In = 16'h0000; Cnt = 4'd0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            chk("a_busy", {31'd0, busy}, {31'd0, (c <= 4)});
            chk("a_done", {31'd0, done}, {31'd0, (c == 5)});
            if (c == 2) begin
                start = 1'b1; In = 16'hFFFF; Cnt = 4'd0; Op = 1'b1;
            end else if (c == 3) begin
                start = 1'b0;
            end
        end
        chk("a_out", {16'd0, Out}, 32'h0010);
        $display("job A In=0001 Cnt=4 Op=0 -> Out=%h (exp 0010)", Out);
        start = 1'b1; In = 16'h0003; Cnt = 4'd2; Op = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; In = 16'h0000;
        for (int c = 6; c <= 8; c++) begin
            if (c > 6) @(negedge clk);
            chk("b_busy", {31'd0, busy}, {31'd0, (c <= 7)});
            chk("b_done", {31'd0, done}, {31'd0, (c == 8)});
            if (c <= 7) chk("b_hold", {16'd0, Out}, 32'h0010);
        end
        chk("b_out", {16'd0, Out}, 32'h000C);
        $display("job B In=0003 Cnt=2 Op=0 -> Out=%h (exp 000C)", Out);
        @(negedge clk);

        // Reset in cycle 4 of a Cnt=8 job.
        start = 1'b1; In = 16'h00FF; Cnt = 4'd8; Op = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 4; c++) @(negedge clk);
        chk("r_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_done", {31'd0, done}, 32'd0);
        chk("r_out",  {16'd0, Out}, 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("r_nodone", {31'd0, done}, 32'd0);
        end
        $display("reset abort -> Out=%h busy=%0d done=%0d", Out, busy, done);
        last_out = 16'h0000;

        // Sweep every count and both operations against a rotate/shift model.
        for (int op = 0; op < 2; op++) begin
            for (int k = 0; k < 16; k++) begin
                rin = 16'($urandom);
                dbl = {rin, rin} << k;
                exp_r = (op == 1) ? dbl[31:16] : 16'(rin << k);
                run_job(rin, 4'(k), op[0], exp_r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
